// File: rtl/sha256_k_sequencer.sv
// SHA-256 round-constant sequencer: steps K[0..ROUNDS-1], LANES words per cycle, under start/adv.
// Optional per-lane parity output k_par is enabled by defining SHA_K_PARITY_EN.
module sha256_k_sequencer #(
    parameter int ROUNDS = 64,
    parameter int LANES  = 1,
    parameter int IDX_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  adv,
    input  logic                  abort,
    output logic [32*LANES-1:0]   k_out,
    output logic                  k_valid,
    output logic                  k_last,
    output logic [IDX_W-1:0]      round_idx,
    output logic                  busy,
    output logic                  done
`ifdef SHA_K_PARITY_EN
   ,output logic [LANES-1:0]      k_par
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - LANES);
    localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

    function automatic logic [32*LANES-1:0] k_group(input logic [IDX_W-1:0] base);
        logic [32*LANES-1:0] g;
        for (int j = 0; j < LANES; j++) begin
            g[32*j +: 32] = K_ROM[6'(int'(base) + j)];
        end
        return g;
    endfunction

    state_t                state_q, state_d;
    logic [32*LANES-1:0]   k_out_q, k_out_d;
    logic                  k_valid_q, k_valid_d;
    logic                  k_last_q, k_last_d;
    logic [IDX_W-1:0]      round_idx_q, round_idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      next_idx;

    assign next_idx = round_idx_q + STEP;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d     = state_q;
        k_out_d     = k_out_q;
        k_valid_d   = k_valid_q;
        k_last_d    = k_last_q;
        round_idx_d = round_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            k_out_d     = '0;
            k_valid_d   = 1'b0;
            k_last_d    = 1'b0;
            round_idx_d = '0;
            busy_d      = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    k_out_d     = '0;
                    k_valid_d   = 1'b0;
                    k_last_d    = 1'b0;
                    round_idx_d = '0;
                    busy_d      = 1'b0;
                    if (start) begin
                        state_d   = RUN;
                        k_out_d   = k_group('0);
                        k_valid_d = 1'b1;
                        k_last_d  = (LAST_IDX == '0);
                        busy_d    = 1'b1;
                    end
                end
                RUN: begin
                    if (adv && k_last_q) begin
                        state_d     = DONE;
                        k_out_d     = '0;
                        k_valid_d   = 1'b0;
                        k_last_d    = 1'b0;
                        round_idx_d = '0;
                        done_d      = 1'b1;
                    end else if (adv) begin
                        round_idx_d = next_idx;
                        k_out_d     = k_group(next_idx);
                        k_last_d    = (next_idx == LAST_IDX);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_out_q     <= '0;
            k_valid_q   <= 1'b0;
            k_last_q    <= 1'b0;
            round_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q     <= state_d;
            k_out_q     <= k_out_d;
            k_valid_q   <= k_valid_d;
            k_last_q    <= k_last_d;
            round_idx_q <= round_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign k_out     = k_out_q;
    assign k_valid   = k_valid_q;
    assign k_last    = k_last_q;
    assign round_idx = round_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SHA_K_PARITY_EN
    logic [LANES-1:0] k_par_q, k_par_d;

    // k_out_d is zero whenever k_valid_d is low, so parity follows to 0 as well.
    always_comb begin
        k_par_d = '0;
        for (int j = 0; j < LANES; j++) begin
            k_par_d[j] = ^k_out_d[32*j +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) k_par_q <= '0;
        else        k_par_q <= k_par_d;
    end

    assign k_par = k_par_q;
`endif

endmodule
